// File: rtl/axis_multi_dac_pacer_if.sv
// AXI-Stream frame channel used to feed the multi-channel DAC pacer.
//   tdata  : packed multi-channel frame (one lane per channel)
//   tvalid : source has a frame on tdata
//   tready : sink can take the frame this cycle
// master modport = frame source (DMA / sample generator), slave = pacer.
interface axis_multi_dac_pacer_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_multi_dac_pacer.sv
// N-channel DAC stream pacer. Frames arrive over AXI-Stream, are buffered in
// a frame FIFO and are replayed one frame per slot of P = max(divider+1, N)
// cycles, time-multiplexed onto a single DAC word bus.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axis                 frame input (slave modport), lane k = channel k
//   cfg_enable             start/stop playback (stop completes current slot)
//   cfg_divider            frame period minus 1, in aclk cycles
//   cfg_underrun_midscale  0 = repeat last frame on underrun, 1 = midscale
//   cfg_twos_comp          invert each word's MSB (two's comp -> offset bin)
//   dac_data_out/sel/strobe  registered DAC word, channel index, word valid
//   dac_rst_out            DAC reset, high while idle
//   fifo_level             frames currently buffered
//   underrun_count         saturating count of empty slots
module axis_multi_dac_pacer #(
  parameter int NUM_CHANNELS   = 2,
  parameter int DAC_DATA_WIDTH = 14,
  parameter int LANE_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int DIV_WIDTH      = 16,
  parameter int SEL_WIDTH      = $clog2(NUM_CHANNELS)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axis_multi_dac_pacer_if.slave       s_axis,
  input  logic                        cfg_enable,
  input  logic [DIV_WIDTH-1:0]        cfg_divider,
  input  logic                        cfg_underrun_midscale,
  input  logic                        cfg_twos_comp,
  output logic [DAC_DATA_WIDTH-1:0]   dac_data_out,
  output logic [SEL_WIDTH-1:0]        dac_sel_out,
  output logic                        dac_strobe_out,
  output logic                        dac_rst_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = NUM_CHANNELS * DAC_DATA_WIDTH;
  localparam logic [DAC_DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DAC_DATA_WIDTH-1){1'b0}}};
  localparam logic [FW-1:0]             MID_FRAME = {NUM_CHANNELS{MIDSCALE}};
  localparam logic [DIV_WIDTH-1:0]      MIN_PM1   = DIV_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [AW:0]               FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]               PREFILL   = (AW+1)'(2);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  function automatic logic [DAC_DATA_WIDTH-1:0] lane_of(input logic [FW-1:0] f,
                                                        input logic [SEL_WIDTH-1:0] idx);
    lane_of = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      if (idx == SEL_WIDTH'(k)) lane_of = f[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH];
  endfunction

  function automatic logic [DAC_DATA_WIDTH-1:0] to_offset(input logic [DAC_DATA_WIDTH-1:0] w,
                                                          input logic flip);
    to_offset = w ^ {flip, {(DAC_DATA_WIDTH-1){1'b0}}};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                     state, state_nxt;
  logic [DIV_WIDTH-1:0]       cnt, cnt_nxt, per_m1, pm1_now;
  logic                       stop_req, stop_req_nxt;
  logic                       rdy_en, full, empty, push, pop, slot_start, slot_last;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [FW-1:0]              mem [FIFO_DEPTH];
  logic [FW-1:0]              frame_in, last_frame, slot_frame, frame_p0;
  logic                       slot_mid, mid_p0, vld_p0;
  logic [DAC_DATA_WIDTH-1:0]  word_p0;
  logic [SEL_WIDTH-1:0]       sel_p0;
  logic                       unused_tdata;

  // Only the low DAC_DATA_WIDTH bits of each lane are stored.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      frame_in[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = s_axis.tdata[k*LANE_WIDTH +: DAC_DATA_WIDTH];
  end
  assign unused_tdata = ^s_axis.tdata;

  // tready is held low for the first cycle out of reset via rdy_en.
  assign full          = (fifo_level == FULL_LVL);
  assign empty         = (fifo_level == '0);
  assign s_axis.tready = rdy_en & ~full;
  assign push          = s_axis.tvalid & s_axis.tready;
  assign slot_start    = (state == S_RUN) && (cnt == '0);
  assign pop           = slot_start & ~empty;

  // Period is never shorter than one word per channel; pm1_now >= 1 so a
  // slot can never end on count 0.
  assign pm1_now   = (cfg_divider < MIN_PM1) ? MIN_PM1 : cfg_divider;
  assign slot_last = (cnt != '0) && (cnt == per_m1);

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // A stop request seen anywhere in a slot is remembered so the slot still
  // completes even if enable comes back before its end.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stop_req_nxt = stop_req;
    case (state)
      S_IDLE: begin
        stop_req_nxt = 1'b0;
        if (cfg_enable) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!cfg_enable) begin
          state_nxt = S_IDLE;
        end else if (fifo_level >= PREFILL) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!cfg_enable) stop_req_nxt = 1'b1;
        if (slot_last) begin
          cnt_nxt = '0;
          if (stop_req || !cfg_enable) state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      cnt            <= '0;
      stop_req       <= 1'b0;
      per_m1         <= MIN_PM1;
      underrun_count <= '0;
      last_frame     <= MID_FRAME;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stop_req <= stop_req_nxt;
      if (slot_start) begin
        per_m1 <= pm1_now;
        if (!empty) last_frame     <= mem[rd_ptr];
        else        underrun_count <= sat_inc16(underrun_count);
      end
    end
  end

  // Stage p0: pick the slot's frame (FIFO head, held frame or midscale) and
  // the word for the current count. Midscale is already offset-binary, so it
  // is flagged to bypass the MSB flip.
  always_comb begin
    frame_p0 = slot_frame;
    mid_p0   = slot_mid;
    if (cnt == '0) begin
      if (!empty) begin
        frame_p0 = mem[rd_ptr];
        mid_p0   = 1'b0;
      end else if (cfg_underrun_midscale) begin
        frame_p0 = MID_FRAME;
        mid_p0   = 1'b1;
      end else begin
        frame_p0 = last_frame;
        mid_p0   = 1'b0;
      end
    end
  end

  assign sel_p0  = cnt[SEL_WIDTH-1:0];
  assign word_p0 = lane_of(frame_p0, sel_p0);
  assign vld_p0  = (state == S_RUN) && (cnt <= MIN_PM1);

  always_ff @(posedge aclk) begin
    if (slot_start) begin
      slot_frame <= frame_p0;
      slot_mid   <= mid_p0;
    end
  end

  // Stage p0 -> output register. dac_rst_out follows the state with the
  // same one-cycle lag as the data words.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dac_data_out   <= '0;
      dac_sel_out    <= '0;
      dac_strobe_out <= 1'b0;
      dac_rst_out    <= 1'b1;
    end else begin
      dac_strobe_out <= vld_p0;
      dac_rst_out    <= (state == S_IDLE);
      if (vld_p0) begin
        dac_data_out <= to_offset(word_p0, cfg_twos_comp & ~mid_p0);
        dac_sel_out  <= sel_p0;
      end
    end
  end
endmodule

// File: doc/axis_multi_dac_pacer.md
Name: axis_multi_dac_pacer

Overview:
- Parametrised N-channel DAC stream engine that accepts packed multi-channel sample frames over AXI-Stream and buffers them in a frame FIFO.
- Emits frames at a programmable rate, time-multiplexed onto one DAC data bus with a channel select and a per-word strobe.
- Handles underrun (hold-last or midscale) and optional two's-complement to offset-binary conversion.
- Sits between the DMA/sample-generator stream and the DAC output-register stage.

Parameters:
- NUM_CHANNELS, 2, channels per frame; range 2..8.
- DAC_DATA_WIDTH, 14, DAC word width.
- LANE_WIDTH, 16, bits per channel lane in s_axis_tdata; must be >= DAC_DATA_WIDTH; the low DAC_DATA_WIDTH bits of each lane are used.
- FIFO_DEPTH, 16, frame FIFO depth in frames; power of 2, >= 2.
- DIV_WIDTH, 16, width of the rate divider.
- SEL_WIDTH, $clog2(NUM_CHANNELS), channel select width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- s_axis_tdata  in  NUM_CHANNELS*LANE_WIDTH  frame; channel k occupies lane k, bits [k*LANE_WIDTH +: DAC_DATA_WIDTH].
- s_axis_tvalid  in  1  frame valid.
- s_axis_tready  out  1  FIFO can accept a frame.
- cfg_enable  in  1  start/stop playback.
- cfg_divider  in  DIV_WIDTH  frame period minus 1, in aclk cycles.
- cfg_underrun_midscale  in  1  0 = hold last frame on underrun; 1 = output midscale.
- cfg_twos_comp  in  1  1 = invert the MSB of each word (two's complement to offset binary).
- dac_data_out  out  DAC_DATA_WIDTH  registered DAC word.
- dac_sel_out  out  SEL_WIDTH  channel index of dac_data_out.
- dac_strobe_out  out  1  dac_data_out/dac_sel_out valid this cycle.
- dac_rst_out  out  1  DAC reset; high in reset and in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- underrun_count  out  16  saturating underrun slot count.

Behaviour:
- Reset is synchronous and active-low on aresetn; clock is aclk. All state is on aclk.
- Reset values:
  - s_axis_tready = 0.
  - dac_data_out = 0, dac_sel_out = 0, dac_strobe_out = 0, dac_rst_out = 1.
  - fifo_level = 0, underrun_count = 0.
  - Last-frame register = midscale (MSB = 1, other bits 0).
  - State = IDLE.
- FIFO:
  - s_axis_tready = ~full, from the first cycle after reset. A write happens when tvalid & tready.
  - Simultaneous push and pop when full is not allowed, because tready is low. Simultaneous push and pop at any other level leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Frames are accepted in every state, including IDLE.
- Period: P = max(cfg_divider+1, NUM_CHANNELS). cfg_divider is sampled at the start of each slot.
- State machine:
  - IDLE: dac_rst_out = 1, strobe = 0. Go to ARM when cfg_enable = 1.
  - ARM: dac_rst_out = 0. Wait until fifo_level >= 2 (prefill), then go to RUN and start a slot on the next cycle.
  - RUN:
    - A slot counter runs 0..P-1.
    - At count 0: pop one frame if the FIFO is non-empty. If it is empty, this is an underrun: increment underrun_count (saturating at 0xFFFF) and use the last frame if cfg_underrun_midscale = 0, or midscale if it is 1.
    - Counts 0..NUM_CHANNELS-1: register channel c = count. dac_strobe_out = 1 and dac_sel_out = c on the following cycle (output latency 1 cycle).
    - Remaining counts: strobe = 0; dac_data_out and dac_sel_out hold.
    - A popped frame updates the last-frame register; midscale substitution does not.
  - Stop: if cfg_enable = 0 in RUN, finish the current slot (all N words emitted), then go to IDLE. Deassertion in ARM returns to IDLE immediately.
- Conversion: when cfg_twos_comp = 1, the MSB of each word is inverted at output. It is applied per word and is also applied to substituted frames. Midscale is defined in the output (offset-binary) domain and is never inverted.
- Latency: a frame written at cycle t into an empty FIFO in RUN reaches dac_data_out at the next slot start + 1.
- Mid-operation reset: the FIFO is flushed, the counters are cleared and the outputs return to their reset values on the next edge.

Test Plan:
- Basic order: N=2, divider=9, twos_comp=0; push frames {a=0x0100,b=0x0200}, {0x0300,0x0400}, then enable. Expected: strobes pair sel 0,1 with 0x0100,0x0200, then 0x0300,0x0400; consecutive strobe pairs start 10 cycles apart.
- Underrun hold: push 2 frames, let them drain, mode 0. Expected: the third slot repeats the last frame, underrun_count = 1, and the counter increments once per empty slot. Repeat in mode 1: expected 0x2000 on both channels.
- Two's complement: with twos_comp=1, push lanes 0x3FFF and 0x0000. Expected outputs 0x1FFF and 0x2000.
- Backpressure: disabled, push FIFO_DEPTH+3 frames continuously. Expected: tready drops after 16 frames, fifo_level = 16, and no frame is lost or reordered after enable.
- Divider clamp: N=4, divider=0. Expected: the period is 4 cycles and strobe is held continuously high with sel cycling 0,1,2,3.
- Stop and reset: drop cfg_enable on slot count 1. Expected: the slot completes, then dac_rst_out = 1. Assert aresetn=0 mid-slot. Expected: every output takes its reset value on the next edge and fifo_level = 0.
